// File: rtl/pointing_device_gen2.sv
// pointing_device_gen2: CD-i maneuvering-device emulator turning MiSTer joystick/analog input into the pointer byte stream
module pointing_device_gen2 #(
  parameter int         BYTE_INTERVAL = 56250,
  parameter int         LATCH_LEAD    = 10,
  parameter logic [7:0] DEVICE_ID     = 8'hCA,
  parameter int         SLOW_STEP     = 1,
  parameter int         FAST_STEP     = 2,
  parameter int         RAMP_LEN      = 5,
  parameter int         DEADZONE      = 8,
  parameter int         ANALOG_SHIFT  = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] mister_joystick_i,
  input  logic [15:0] mister_analog_i,
  input  logic        analog_mode_i,
  input  logic        rts_i,
  output logic [7:0]  serial_out_data_o,
  output logic        serial_out_write_o
);
  localparam int CW = $clog2(BYTE_INTERVAL + 1);
  localparam int SW = $clog2(RAMP_LEN + 2);
  typedef enum logic [1:0] {S_ID, S_B0, S_B1, S_B2} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] speed_q, speed_d;
  logic          xmit_q, xmit_d;
  logic [7:0]    f0_q, f0_d, f1_q, f1_d, f2_q, f2_d;
  logic [7:0]    x_q, x_d, y_q, y_d, sx_q, sx_d, sy_q, sy_d;
  logic          b1_q, b1_d, b2_q, b2_d, sb1_q, sb1_d, sb2_q, sb2_d;
  logic [7:0]    data_q, data_d;
  logic          write_q, write_d;
  logic [7:0]    step, nx, ny;
  logic          nb1, nb2, latch;
  logic          unused_joy;
  function automatic logic [7:0] dig(input logic pos, input logic neg, input logic [7:0] s);
    return (pos == neg) ? 8'd0 : pos ? s : 8'd0 - s;
  endfunction
  // 9-bit working width keeps -128 representable as a magnitude
  function automatic logic [7:0] ana(input logic [7:0] a);
    logic signed [8:0] w, m;
    w = {a[7], a};
    m = w[8] ? -w : w;
    return (m <= 9'(DEADZONE)) ? 8'd0 : 8'(w >>> ANALOG_SHIFT);
  endfunction
  assign unused_joy = ^mister_joystick_i[15:6];
  assign step = (speed_q >= SW'(RAMP_LEN)) ? 8'(FAST_STEP) : 8'(SLOW_STEP);
  assign nx = analog_mode_i ? ana(mister_analog_i[7:0]) : dig(mister_joystick_i[0], mister_joystick_i[1], step);
  assign ny = analog_mode_i ? ana(mister_analog_i[15:8]) : dig(mister_joystick_i[2], mister_joystick_i[3], step);
  assign nb1 = mister_joystick_i[5];
  assign nb2 = mister_joystick_i[4];
  assign latch = !rts_i && state_q == S_B0 && cnt_q == CW'(LATCH_LEAD);
  // slot timing, packet latch and byte emission
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - CW'(1);
    speed_d = speed_q;
    xmit_d = xmit_q;
    f0_d = f0_q;
    f1_d = f1_q;
    f2_d = f2_q;
    x_d = x_q;
    y_d = y_q;
    b1_d = b1_q;
    b2_d = b2_q;
    sx_d = sx_q;
    sy_d = sy_q;
    sb1_d = sb1_q;
    sb2_d = sb2_q;
    data_d = data_q;
    write_d = 1'b0;
    if (latch) begin
      x_d = nx;
      y_d = ny;
      b1_d = nb1;
      b2_d = nb2;
      f0_d = {2'b11, nb1, nb2, ny[7:6], nx[7:6]};
      f1_d = {2'b10, nx[5:0]};
      f2_d = {2'b10, ny[5:0]};
      xmit_d = {nb1, nb2, nx, ny} != {sb1_q, sb2_q, sx_q, sy_q} || nx != 8'd0 || ny != 8'd0;
      speed_d = (analog_mode_i || mister_joystick_i[3:0] == 4'd0) ? '0 :
                (speed_q >= SW'(RAMP_LEN)) ? SW'(RAMP_LEN) : speed_q + SW'(1);
    end
    if (rts_i) begin
      state_d = S_ID;
      cnt_d = CW'(BYTE_INTERVAL);
    end else if (cnt_q == '0) begin
      cnt_d = CW'(BYTE_INTERVAL);
      write_d = state_q != S_B0 || xmit_q;
      data_d = state_q == S_ID ? DEVICE_ID : state_q == S_B1 ? f1_q : state_q == S_B2 ? f2_q : xmit_q ? f0_q : data_q;
      state_d = state_q == S_ID ? S_B0 : state_q == S_B1 ? S_B2 : state_q == S_B2 ? S_B0 : xmit_q ? S_B1 : S_B0;
      if (state_q == S_B0 && xmit_q) begin
        sx_d = x_q;
        sy_d = y_q;
        sb1_d = b1_q;
        sb2_d = b2_q;
      end
    end
  end
  // state register, cleared asynchronously
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_ID;
      cnt_q <= CW'(BYTE_INTERVAL);
      speed_q <= '0;
      xmit_q <= 1'b0;
      f0_q <= 8'hC0;
      f1_q <= 8'h80;
      f2_q <= 8'h80;
      x_q <= 8'd0;
      y_q <= 8'd0;
      b1_q <= 1'b0;
      b2_q <= 1'b0;
      sx_q <= 8'd0;
      sy_q <= 8'd0;
      sb1_q <= 1'b0;
      sb2_q <= 1'b0;
      data_q <= 8'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      speed_q <= speed_d;
      xmit_q <= xmit_d;
      f0_q <= f0_d;
      f1_q <= f1_d;
      f2_q <= f2_d;
      x_q <= x_d;
      y_q <= y_d;
      b1_q <= b1_d;
      b2_q <= b2_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      sb1_q <= sb1_d;
      sb2_q <= sb2_d;
      data_q <= data_d;
      write_q <= write_d;
    end
  end
  assign serial_out_data_o = data_q;
  assign serial_out_write_o = write_q;
endmodule
